// File: rtl/sltu_sort_sequencer.sv
`timescale 1ns/1ps
// sltu: unsigned less-than via the borrow of an (N+1)-bit subtract; combinational.
// Latency: 0 cycles. Backpressure: none (pure function of a and b).
// Used as the single shared comparator of the sort sequencer below.
module sltu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);
    logic [N-1:0] diff_unused;

    // The borrow out of the top bit is set exactly when a < b as unsigned.
    assign {out, diff_unused} = {1'b0, a} - {1'b0, b};
endmodule

// sltu_sort_sequencer: loads DEPTH words, bubble-sorts them in place with one sltu, streams them out ascending.
// Latency: DEPTH-1 .. (DEPTH-1)^2 sort cycles after the last word is loaded, one compare per cycle.
// Backpressure: in_ready only in LOAD; out_ready low holds out_data/out_last; no block overlap.
module sltu_sort_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic [$clog2(DEPTH*DEPTH):0]   swap_count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int SCW = $clog2(DEPTH*DEPTH) + 1;

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_J   = PW'(DEPTH - 2);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SORT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  data_buf [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] j;
    logic [PW-1:0] j_nxt;
    logic [PW-1:0] p;
    logic          pass_swapped;
    logic          lt;
    logic          load_fire;
    logic          do_swap;
    logic          pass_end;
    logic          sort_done;

    assign j_nxt = j + PW'(1);

    sltu #(.N(N)) u_sltu (
        .a   (data_buf[j_nxt]),
        .b   (data_buf[j]),
        .out (lt)
    );

    assign in_ready  = (state == LOAD);
    assign busy      = (state == SORT);
    assign out_valid = (state == DRAIN);
    assign out_data  = data_buf[rd_ptr];
    assign out_last  = out_valid && (rd_ptr == LAST_IDX);

    assign load_fire = in_valid && in_ready;
    assign do_swap   = busy && lt;
    assign pass_end  = (j == LAST_J);
    // Stop after a clean pass, or once the (DEPTH-1)th pass has completed.
    assign sort_done = pass_end && (!(pass_swapped || lt) || (p == LAST_J));

    // Buffer contents carry no reset; control never reads them before a full load.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            data_buf[wr_ptr] <= in_data;
        end else if (do_swap) begin
            data_buf[j]     <= data_buf[j_nxt];
            data_buf[j_nxt] <= data_buf[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            j            <= '0;
            p            <= '0;
            pass_swapped <= 1'b0;
            swap_count   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        if (wr_ptr == '0) begin
                            swap_count <= '0;
                        end
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr       <= '0;
                            j            <= '0;
                            p            <= '0;
                            pass_swapped <= 1'b0;
                            state        <= SORT;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                SORT: begin
                    if (lt) begin
                        swap_count <= swap_count + SCW'(1);
                    end
                    if (sort_done) begin
                        state <= DRAIN;
                    end else if (pass_end) begin
                        j            <= '0;
                        p            <= p + PW'(1);
                        pass_swapped <= 1'b0;
                    end else begin
                        j            <= j_nxt;
                        pass_swapped <= pass_swapped || lt;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + PW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_sltu_sort_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for sltu_sort_sequencer: directed blocks, backpressure, mid-sort reset,
// then randomized blocks checked against a queue-sort / inversion-count reference model.
module tb_sltu_sort_sequencer;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int SCW   = $clog2(DEPTH*DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic [SCW-1:0] swap_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] blk [DEPTH];
    logic [N-1:0] exp_q [$];
    int           exp_inv;
    int           exp_cyc;

    sltu_sort_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sorted order from a queue sort; swaps = inversion count; the number of
    // passes that swap equals the largest count of strictly-greater words ahead of any word.
    task automatic build_model();
        int maxk;
        int passes;
        exp_q   = {};
        exp_inv = 0;
        maxk    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int cnt;
            exp_q.push_back(blk[i]);
            cnt = 0;
            for (int h = 0; h < i; h++) begin
                if (blk[h] > blk[i]) cnt++;
            end
            exp_inv += cnt;
            if (cnt > maxk) maxk = cnt;
        end
        exp_q.sort();
        passes  = (maxk + 1 < DEPTH - 1) ? maxk + 1 : DEPTH - 1;
        exp_cyc = passes * (DEPTH - 1);
    endtask

    task automatic load_block(input int gap);
        build_model();
        for (int i = 0; i < DEPTH; i++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap)) tick();
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            check("in_ready_load", in_ready, 1);
            check("busy_load", busy, 0);
            tick();
            if (i == 0) check("swap_count_clear", swap_count, 0);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready
    task automatic finish_block(input int mode);
        int cyc;
        int idx;
        int step;
        cyc = 0;
        while (busy && cyc < 200) begin
            in_valid = $urandom_range(0, 1);
            in_data  = $urandom;
            cyc++;
            tick();
        end
        in_valid = 1'b0;
        check("sort_cycles", cyc, exp_cyc);
        check("swap_count_sort", swap_count, exp_inv);

        idx  = 0;
        step = 0;
        while (idx < DEPTH && step < 500) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (step % 4 == 0) || (step % 4 == 3);
                default: out_ready = $urandom_range(0, 1);
            endcase
            in_valid = $urandom_range(0, 1);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_q[idx]);
            check("out_last", out_last, (idx == DEPTH - 1));
            check("in_ready_drain", in_ready, 0);
            tick();
            if (out_ready) idx++;
            step++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_done", idx, DEPTH);
        check("out_valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("swap_count_hold", swap_count, exp_inv);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_swap_count", swap_count, 0);

        blk = '{32'd1, 32'd2, 32'd3, 32'd4};
        load_block(0);
        finish_block(0);

        blk = '{32'd4, 32'd3, 32'd2, 32'd1};
        load_block(0);
        finish_block(0);

        blk = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1};
        load_block(0);
        finish_block(0);

        blk = '{32'd5, 32'd5, 32'd5, 32'd5};
        load_block(0);
        finish_block(0);

        blk = '{32'd9, 32'd2, 32'd7, 32'd2};
        load_block(0);
        finish_block(1);

        // Reset in the middle of sorting 4,3,2,1 must abandon the block.
        blk = '{32'd4, 32'd3, 32'd2, 32'd1};
        load_block(0);
        tick();
        tick();
        check("mid_sort_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_swap_count", swap_count, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        blk = '{32'd7, 32'd6, 32'd9, 32'd8};
        load_block(0);
        finish_block(0);

        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
                blk[i] = (b % 2 == 1) ? N'($urandom_range(0, 3)) : N'($urandom);
            end
            load_block(2);
            finish_block(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
